// File: rtl/NV_NVDLA_reset_pkg.sv
// Shared encodings and limits for the NVDLA reset sequencer.
// The software-reset path is gated by NVDLA_RESET_SEQ_SW_REQ_EN in the top level.
package NV_NVDLA_reset_pkg;

    localparam int CNT_W      = 8;
    localparam int MAX_NUM_CH = 8;
    localparam int IDX_W      = $clog2(MAX_NUM_CH + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [2:0] ST_IDLE_RST = 3'd0;
    localparam logic [2:0] ST_SYNC     = 3'd1;
    localparam logic [2:0] ST_RELEASE  = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_SWRST    = 3'd4;

endpackage

// File: rtl/NV_NVDLA_reset_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser of DEPTH flops.
// Exposes the final stage and the stage before it so the sequencer can act on the same edge the final stage goes high.
module NV_NVDLA_reset_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rstn_early_o,
    output logic rstn_o
);

    logic [DEPTH-1:0] chain_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], 1'b1};
        end
    end

    assign rstn_early_o = chain_q[DEPTH-2];
    assign rstn_o       = chain_q[DEPTH-1];

endmodule

// File: rtl/nv_nvdla_reset_seq.sv
// NVDLA reset sequencer: synchronised release, staggered per-channel deassertion, optional software channel reset.
// Define NVDLA_RESET_SEQ_SW_REQ_EN to build the software-reset (SWRST) path; otherwise sw_rst_req is ignored.
module nv_nvdla_reset_seq
    import NV_NVDLA_reset_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int STAGGER_CYC = 8,
    parameter int SW_RST_CYC  = 16
) (
    input  logic              nvdla_clk,
    input  logic              dla_reset_rstn,
    input  logic              direct_reset_,
    input  logic              test_mode,
    input  logic [NUM_CH-1:0] sw_rst_req,
    output logic              sw_rst_ack,
    output logic [NUM_CH-1:0] synced_rstn,
    output logic              rst_done
);

    localparam cnt_t STAGGER_LD = cnt_t'(STAGGER_CYC);
    localparam idx_t NUM_CH_IDX = idx_t'(NUM_CH);

    logic              sync_rstn_early;
    logic              sync_rstn;
    logic [2:0]        state_q, state_d;
    cnt_t              stag_cnt_q, stag_cnt_d;
    idx_t              idx_q, idx_d;
    logic [NUM_CH-1:0] chan_q, chan_d;
    logic              done_q, done_d;

`ifdef NVDLA_RESET_SEQ_SW_REQ_EN
    localparam cnt_t SW_LD = cnt_t'(SW_RST_CYC);

    cnt_t              sw_cnt_q, sw_cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              ack_q, ack_d;
`else
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = ^sw_rst_req;
`endif

    NV_NVDLA_reset_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk_i        (nvdla_clk),
        .rst_ni       (dla_reset_rstn),
        .rstn_early_o (sync_rstn_early),
        .rstn_o       (sync_rstn)
    );

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        stag_cnt_d = stag_cnt_q;
        idx_d      = idx_q;
        chan_d     = chan_q;
`ifdef NVDLA_RESET_SEQ_SW_REQ_EN
        sw_cnt_d   = sw_cnt_q;
        mask_d     = mask_q;
        ack_d      = 1'b0;
`endif
        case (state_q)
            // Leave on the edge the synchroniser's last stage captures 1, so channel 0 lands SYNC_DEPTH+1 edges after release.
            ST_IDLE_RST: begin
                if (sync_rstn_early) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (sync_rstn) begin
                    state_d    = ST_RELEASE;
                    chan_d[0]  = 1'b1;
                    idx_d      = idx_t'(1);
                    stag_cnt_d = STAGGER_LD;
                end
            end
            ST_RELEASE: begin
                if (idx_q == NUM_CH_IDX) begin
                    state_d    = ST_RUN;
                    stag_cnt_d = '0;
                end else if (stag_cnt_q == cnt_t'(1)) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_q == idx_t'(i)) begin
                            chan_d[i] = 1'b1;
                        end
                    end
                    idx_d      = idx_q + idx_t'(1);
                    stag_cnt_d = (idx_q == NUM_CH_IDX - idx_t'(1)) ? '0 : STAGGER_LD;
                end else begin
                    stag_cnt_d = stag_cnt_q - cnt_t'(1);
                end
            end
            ST_RUN: begin
`ifdef NVDLA_RESET_SEQ_SW_REQ_EN
                if (|sw_rst_req) begin
                    state_d  = ST_SWRST;
                    mask_d   = sw_rst_req;
                    chan_d   = chan_q & ~sw_rst_req;
                    ack_d    = 1'b1;
                    sw_cnt_d = SW_LD;
                end
`endif
            end
`ifdef NVDLA_RESET_SEQ_SW_REQ_EN
            ST_SWRST: begin
                if (sw_cnt_q == cnt_t'(1)) begin
                    state_d  = ST_RUN;
                    chan_d   = chan_q | mask_q;
                    mask_d   = '0;
                    sw_cnt_d = '0;
                end else begin
                    sw_cnt_d = sw_cnt_q - cnt_t'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE_RST;
            end
        endcase
        done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            state_q    <= ST_IDLE_RST;
            stag_cnt_q <= '0;
            idx_q      <= '0;
            chan_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stag_cnt_q <= stag_cnt_d;
            idx_q      <= idx_d;
            chan_q     <= chan_d;
            done_q     <= done_d;
        end
    end

`ifdef NVDLA_RESET_SEQ_SW_REQ_EN
    always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            sw_cnt_q <= '0;
            mask_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            sw_cnt_q <= sw_cnt_d;
            mask_q   <= mask_d;
            ack_q    <= ack_d;
        end
    end

    assign sw_rst_ack = ack_q & ~test_mode;
`else
    assign sw_rst_ack = 1'b0;
`endif

    // Test mode bypasses the sequencer at the outputs only; the FSM keeps stepping underneath.
    assign synced_rstn = test_mode ? {NUM_CH{direct_reset_}} : chan_q;
    assign rst_done    = done_q & ~test_mode;

endmodule
